// File: rtl/cpu_trace_buffer.sv
// rtl/cpu_trace_buffer.sv - circular execution-trace capture with PC trigger and oldest-first drain
module cpu_trace_buffer #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 16,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [XLEN-1:0] i_pc,
    input  logic [31:0]     i_instr,
    input  logic [XLEN-1:0] i_result,
    input  logic            i_arm,
    input  logic            i_stop,
    input  logic            i_mode,
    input  logic            i_trig_en,
    input  logic [XLEN-1:0] i_trig_pc,
    input  logic [CW-1:0]   i_post_count,
    output logic            o_rd_valid,
    input  logic            i_rd_ready,
    output logic [XLEN-1:0] o_rd_pc,
    output logic [31:0]     o_rd_instr,
    output logic [XLEN-1:0] o_rd_result,
    output logic [1:0]      o_state,
    output logic [CW-1:0]   o_count,
    output logic            o_overflow
);
    localparam int AW = $clog2(DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ARMED = 2'd1;
    localparam logic [1:0] S_POST  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [XLEN-1:0] r_mem_pc     [DEPTH];
    logic [31:0]     r_mem_instr  [DEPTH];
    logic [XLEN-1:0] r_mem_result [DEPTH];

    logic [1:0]      r_state;
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic [CW-1:0]   r_remaining;
    logic            r_overflow;
    logic            r_have_last;
    logic [XLEN-1:0] r_last_pc;

    logic w_capturing;
    logic w_qual;
    logic w_write;
    logic w_trig_hit;
    logic w_full;
    logic w_pop;

    assign w_capturing = (r_state == S_ARMED) || (r_state == S_POST);
    assign w_qual      = w_capturing && (!i_mode || !r_have_last || (i_pc != r_last_pc));
    assign w_write     = w_qual && !i_stop && !i_arm;
    assign w_trig_hit  = (r_state == S_ARMED) && i_trig_en && (i_pc == i_trig_pc);
    assign w_full      = (r_count == CW'(DEPTH));
    assign w_pop       = o_rd_valid && i_rd_ready;

    // Storage has no reset: reads are masked by o_rd_valid, so stale contents never escape.
    always_ff @(posedge i_clk) begin
        if (w_write) begin
            r_mem_pc[r_wr_ptr]     <= i_pc;
            r_mem_instr[r_wr_ptr]  <= i_instr;
            r_mem_result[r_wr_ptr] <= i_result;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_remaining <= '0;
            r_overflow  <= 1'b0;
            r_have_last <= 1'b0;
            r_last_pc   <= '0;
        end else if (i_arm) begin
            r_state     <= S_ARMED;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_remaining <= '0;
            r_overflow  <= 1'b0;
            r_have_last <= 1'b0;
        end else if (w_capturing) begin
            if (i_stop) begin
                r_state <= S_DONE;
            end else if (w_qual) begin
                r_wr_ptr    <= r_wr_ptr + AW'(1);
                r_have_last <= 1'b1;
                r_last_pc   <= i_pc;
                if (w_full) begin
                    r_rd_ptr   <= r_rd_ptr + AW'(1);
                    r_overflow <= 1'b1;
                end else begin
                    r_count <= r_count + CW'(1);
                end
                if (r_state == S_ARMED) begin
                    if (w_trig_hit) begin
                        r_remaining <= i_post_count;
                        r_state     <= (i_post_count == '0) ? S_DONE : S_POST;
                    end
                end else begin
                    r_remaining <= r_remaining - CW'(1);
                    if (r_remaining == CW'(1)) begin
                        r_state <= S_DONE;
                    end
                end
            end
        end else if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count  <= r_count - CW'(1);
        end
    end

    assign o_rd_valid  = (r_state == S_DONE) && (r_count != '0);
    assign o_rd_pc     = o_rd_valid ? r_mem_pc[r_rd_ptr]     : '0;
    assign o_rd_instr  = o_rd_valid ? r_mem_instr[r_rd_ptr]  : '0;
    assign o_rd_result = o_rd_valid ? r_mem_result[r_rd_ptr] : '0;
    assign o_state     = r_state;
    assign o_count     = r_count;
    assign o_overflow  = r_overflow;
endmodule

// File: tb/tb_cpu_trace_buffer.sv
// tb/tb_cpu_trace_buffer.sv - scoreboard bench for cpu_trace_buffer (DEPTH 8 and DEPTH 16 instances)
module tb_cpu_trace_buffer;
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] result;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc = '0;
    logic [31:0] instr = '0;
    logic [31:0] result = '0;
    logic        arm = 1'b0;
    logic        stop = 1'b0;
    logic        mode = 1'b0;
    logic        trig_en = 1'b0;
    logic [31:0] trig_pc = '0;
    logic [4:0]  post_count = '0;
    logic        rd_ready8 = 1'b0;
    logic        rd_ready16 = 1'b0;

    logic        rd_valid8, rd_valid16, ovf8, ovf16;
    logic [31:0] rd_pc8, rd_instr8, rd_result8, rd_pc16, rd_instr16, rd_result16;
    logic [1:0]  state8, state16;
    logic [3:0]  count8;
    logic [4:0]  count16;

    int n_cmp = 0;
    int n_bad = 0;
    ent_t q8[$];
    ent_t q16[$];

    always #5 clk = ~clk;

    cpu_trace_buffer #(.XLEN(32), .DEPTH(8)) u_dut8 (
        .i_clk(clk), .i_rst(rst), .i_pc(pc), .i_instr(instr), .i_result(result),
        .i_arm(arm), .i_stop(stop), .i_mode(mode), .i_trig_en(trig_en), .i_trig_pc(trig_pc),
        .i_post_count(post_count[3:0]), .o_rd_valid(rd_valid8), .i_rd_ready(rd_ready8),
        .o_rd_pc(rd_pc8), .o_rd_instr(rd_instr8), .o_rd_result(rd_result8),
        .o_state(state8), .o_count(count8), .o_overflow(ovf8)
    );

    cpu_trace_buffer #(.XLEN(32), .DEPTH(16)) u_dut16 (
        .i_clk(clk), .i_rst(rst), .i_pc(pc), .i_instr(instr), .i_result(result),
        .i_arm(arm), .i_stop(stop), .i_mode(mode), .i_trig_en(trig_en), .i_trig_pc(trig_pc),
        .i_post_count(post_count), .o_rd_valid(rd_valid16), .i_rd_ready(rd_ready16),
        .o_rd_pc(rd_pc16), .o_rd_instr(rd_instr16), .o_rd_result(rd_result16),
        .o_state(state16), .o_count(count16), .o_overflow(ovf16)
    );

    function automatic logic [31:0] instr_of(logic [31:0] p);
        return 32'h0013_0000 ^ p;
    endfunction

    function automatic logic [31:0] result_of(logic [31:0] p);
        return p + 32'h1000_0000;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expect8(input logic [31:0] p);
        ent_t e;
        e.pc = p; e.instr = instr_of(p); e.result = result_of(p);
        q8.push_back(e);
    endtask

    task automatic expect16(input logic [31:0] p);
        ent_t e;
        e.pc = p; e.instr = instr_of(p); e.result = result_of(p);
        q16.push_back(e);
    endtask

    // Monitors: compare the head entry at every accepting handshake.
    always @(negedge clk) begin
        if (!rst && rd_valid8 && rd_ready8) begin
            if (q8.size() == 0) begin
                check("pop8_unexpected", 64'd1, 64'd0);
            end else begin
                ent_t e;
                e = q8.pop_front();
                check("rd_pc8", {32'd0, rd_pc8}, {32'd0, e.pc});
                check("rd_instr8", {32'd0, rd_instr8}, {32'd0, e.instr});
                check("rd_result8", {32'd0, rd_result8}, {32'd0, e.result});
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && rd_valid16 && rd_ready16) begin
            if (q16.size() == 0) begin
                check("pop16_unexpected", 64'd1, 64'd0);
            end else begin
                ent_t e;
                e = q16.pop_front();
                check("rd_pc16", {32'd0, rd_pc16}, {32'd0, e.pc});
                check("rd_instr16", {32'd0, rd_instr16}, {32'd0, e.instr});
                check("rd_result16", {32'd0, rd_result16}, {32'd0, e.result});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_arm();
        arm = 1'b1;
        step();
        arm = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    task automatic sample(input logic [31:0] p);
        pc = p; instr = instr_of(p); result = result_of(p);
        step();
    endtask

    task automatic drain(input logic use16);
        int cyc;
        rd_ready8 = 1'b1;
        rd_ready16 = use16;
        cyc = 0;
        while ((count8 != 0 || (use16 && count16 != 0)) && cyc < 40) begin
            step();
            cyc++;
        end
        rd_ready8 = 1'b0;
        rd_ready16 = 1'b0;
        check("drain_timeout", 64'(cyc >= 40), 64'd0);
        check("q8_left", 64'(q8.size()), 64'd0);
        if (use16) check("q16_left", 64'(q16.size()), 64'd0);
        check("rd_valid8_after_drain", 64'(rd_valid8), 64'd0);
        check("rd_pc8_zero_after_drain", {32'd0, rd_pc8}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        logic [31:0] p;
        logic [31:0] held;
        logic [6:0] pat;

        repeat (2) step();
        check("rst_state", 64'(state8), 64'd0);
        check("rst_count", 64'(count8), 64'd0);
        check("rst_rd_valid", 64'(rd_valid8), 64'd0);
        rst = 1'b0;
        step();

        // Reset asserted asynchronously in the middle of POST.
        trig_en = 1'b1; trig_pc = 32'h10; post_count = 5'd5;
        do_arm();
        for (int i = 0; i < 5; i++) sample(32'(4 * i));
        check("midpost_state", 64'(state8), 64'd2);
        check("midpost_count", 64'(count8), 64'd5);
        #3 rst = 1'b1;
        #1;
        check("async_rst_state", 64'(state8), 64'd0);
        check("async_rst_count", 64'(count8), 64'd0);
        check("async_rst_ovf", 64'(ovf8), 64'd0);
        check("async_rst_rd_valid", 64'(rd_valid8), 64'd0);
        check("async_rst_rd_pc", {32'd0, rd_pc8}, 64'd0);
        step();
        rst = 1'b0;
        trig_en = 1'b0;

        // Five samples then stop.
        do_arm();
        check("armed_state", 64'(state8), 64'd1);
        check("armed_rd_valid", 64'(rd_valid8), 64'd0);
        for (int i = 0; i < 5; i++) sample(32'(4 * i));
        do_stop();
        check("five_state", 64'(state8), 64'd3);
        check("five_count", 64'(count8), 64'd5);
        check("five_ovf", 64'(ovf8), 64'd0);
        expect8(32'h0); expect8(32'h4); expect8(32'h8); expect8(32'hC); expect8(32'h10);
        drain(1'b0);

        // Twelve samples into DEPTH 8: oldest four overwritten.
        do_arm();
        for (int i = 0; i < 12; i++) sample(32'(4 * i));
        do_stop();
        check("wrap_count", 64'(count8), 64'd8);
        check("wrap_ovf", 64'(ovf8), 64'd1);
        for (int i = 4; i < 12; i++) expect8(32'(4 * i));
        drain(1'b0);
        check("ovf_sticky_after_drain", 64'(ovf8), 64'd1);

        // PC trigger at 0x20 with two post-trigger samples.
        trig_en = 1'b1; trig_pc = 32'h20; post_count = 5'd2;
        do_arm();
        check("arm_clears_ovf", 64'(ovf8), 64'd0);
        cyc = 0;
        p = 32'h0;
        while (state16 != 2'd3 && cyc < 30) begin
            sample(p);
            if (p == 32'h20) check("trig_to_post", 64'(state16), 64'd2);
            p = p + 32'h4;
            cyc++;
        end
        check("trig_timeout", 64'(cyc >= 30), 64'd0);
        check("trig_last_pc", {32'd0, pc}, 64'h28);
        check("trig_count16", 64'(count16), 64'd11);
        check("trig_count8", 64'(count8), 64'd8);
        check("trig_ovf8", 64'(ovf8), 64'd1);
        for (int i = 0; i <= 10; i++) expect16(32'(4 * i));
        for (int i = 3; i <= 10; i++) expect8(32'(4 * i));
        drain(1'b1);

        // post_count 0 finishes on the trigger sample itself.
        trig_pc = 32'h8; post_count = 5'd0;
        do_arm();
        sample(32'h0); sample(32'h4); sample(32'h8);
        check("post0_state", 64'(state8), 64'd3);
        check("post0_count", 64'(count8), 64'd3);
        expect8(32'h0); expect8(32'h4); expect8(32'h8);
        drain(1'b0);

        // Stop and trigger together: stop wins, sample dropped.
        trig_pc = 32'h0; post_count = 5'd2;
        do_arm();
        pc = 32'h0; stop = 1'b1;
        step();
        stop = 1'b0;
        check("stop_vs_trig_state", 64'(state8), 64'd3);
        check("stop_vs_trig_count", 64'(count8), 64'd0);
        check("stop_vs_trig_rd_valid", 64'(rd_valid8), 64'd0);

        // Mode 1: each pc held three cycles.
        trig_en = 1'b0; mode = 1'b1;
        do_arm();
        for (int i = 0; i < 4; i++) repeat (3) sample(32'(4 * i));
        do_stop();
        check("mode1_count", 64'(count8), 64'd4);
        expect8(32'h0); expect8(32'h4); expect8(32'h8); expect8(32'hC);

        // Ready pattern 1,0,0,1,1,0,1 against four entries.
        pat = 7'b1011001;
        for (int i = 0; i < 7; i++) begin
            rd_ready8 = pat[i];
            held = rd_pc8;
            step();
            if (!pat[i]) check("stall_hold_pc", {32'd0, rd_pc8}, {32'd0, held});
        end
        rd_ready8 = 1'b0;
        check("pattern_q_left", 64'(q8.size()), 64'd0);
        check("pattern_count", 64'(count8), 64'd0);
        check("pattern_rd_valid", 64'(rd_valid8), 64'd0);
        check("pattern_state", 64'(state8), 64'd3);

        do_arm();
        check("rearm_count", 64'(count8), 64'd0);
        check("rearm_ovf", 64'(ovf8), 64'd0);
        check("rearm_state", 64'(state8), 64'd1);
        mode = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/cpu_trace_buffer.md
# cpu_trace_buffer

Parametrised hardware execution-trace capture for the multicycle RISC-V core. It records PC, instruction and result into a circular buffer of DEPTH entries. Two capture modes are provided: every cycle, or once per instruction. Capture stops on a PC-match trigger after a programmable number of post-trigger samples, or on an explicit stop. After capture, software or a bench drains the buffer oldest-first over a valid/ready port.

## Interface
Parameters:
- XLEN, 32, width of pc and result.
- DEPTH, 16, buffer entries; power of two, at least 2.
- CW, $clog2(DEPTH)+1, width of count and post_count.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  asynchronous reset, active-high.
- pc  in  XLEN  CPU program counter.
- instr  in  32  CPU current instruction.
- result  in  XLEN  CPU result bus.
- arm  in  1  starts a new capture; clears the buffer.
- stop  in  1  ends capture immediately.
- mode  in  1  capture qualifier: 0 = every cycle; 1 = only when pc differs from the last captured pc.
- trig_en  in  1  enables the PC trigger.
- trig_pc  in  XLEN  trigger address.
- post_count  in  CW  samples captured after the trigger sample; valid range 0..DEPTH.
- rd_valid  out  1  head entry available.
- rd_ready  in  1  consumer accepts the head entry.
- rd_pc, rd_instr, rd_result  out  XLEN/32/XLEN  head (oldest) entry.
- state  out  2  0=IDLE, 1=ARMED, 2=POST, 3=DONE.
- count  out  CW  entries held, 0..DEPTH.
- overflow  out  1  sticky; set when an entry was overwritten.

## Operation
- A sample is qualified in ARMED or POST when:
  - mode=0, or
  - mode=1 and (no sample has been captured since arm, or pc != last captured pc).
- Qualified samples write {pc, instr, result} at the write pointer. The write pointer wraps modulo DEPTH.
- When count==DEPTH, a write overwrites the oldest entry, advances the read pointer, keeps count at DEPTH and sets overflow.
- State transitions:
  - IDLE -> ARMED on arm.
  - ARMED -> POST when a qualified sample has trig_en=1 and pc==trig_pc. That sample is written and remaining is loaded with post_count. If post_count==0, the transition goes to DONE instead.
  - POST: each qualified sample is written and decrements remaining; the sample that brings remaining to 0 is written and the state moves to DONE.
  - The trigger compare is ignored in POST.
  - ARMED or POST -> DONE on stop. The sample in that cycle is not written.
  - Any state -> ARMED on arm. Arm clears pointers, count, overflow and the mode-1 history. arm has priority over stop and over the trigger.
- DONE:
  - rd_valid = (count != 0).
  - A pop occurs on rd_valid && rd_ready: read pointer advances, count decrements.
  - At count==0, rd_valid=0 and the state remains DONE until arm.
- rd_valid=0 in IDLE, ARMED and POST. No reads occur during capture.
- rd_* show the head entry combinationally from storage. rd_* equal 0 whenever rd_valid=0.
- pc==trig_pc compares the full XLEN bits.

## Timing
- Reset values: state=IDLE, count=0, overflow=0, rd_valid=0, rd_*=0, pointers=0, remaining=0. Reset takes effect asynchronously and mid-capture.
- arm high at edge N: state=ARMED after N. The first sampled inputs are those present at edge N+1.
- The trigger sample is captured at edge T. state reads POST (or DONE) from T onward. count includes the trigger sample immediately after T.
- In mode 1, a pc held for k cycles yields exactly one entry.
- Pop latency: the next head appears on rd_* in the cycle after the accepting edge.
- rd_* are stable while rd_valid && !rd_ready.
- stop and trigger in the same cycle: stop wins; the sample is not written.

## Test plan
- Reset mid-POST with count=5 -> next cycle state=0, count=0, overflow=0, rd_valid=0, rd_pc=0.
- DEPTH=8, mode=0. Arm, then pc=0,4,8,0xC,0x10 on 5 edges, then stop -> count=5, overflow=0. Drain with rd_ready=1 -> rd_pc 0,4,8,0xC,0x10, then rd_valid=0.
- DEPTH=8, mode=0. 12 samples pc=4*i, i=0..11, then stop -> count=8, overflow=1. Readout pc=0x10..0x2C in order.
- trig_en=1, trig_pc=0x20, post_count=2, pc stepping by 4 from 0 -> DONE after the edge with pc=0x28. Last entry read is 0x28; count=11 with DEPTH=16.
- mode=1, each pc held 3 cycles for pc=0,4,8,0xC, then stop -> count=4, one entry per PC. Arm again -> count=0, overflow=0.
- DONE with count=4, rd_ready pattern 1,0,0,1,1,0,1 -> exactly 4 pops. rd_pc unchanged during stalls; rd_valid drops after the fourth pop.
